imsic_msi_sender: RTL and testbench
===================================

Name: imsic_msi_sender

Overview:
- Transmit end of the IMSIC MSI-info interface.
- Accepts posted MSI writes (address/data) from the bus side and decodes each into the packed {hart_id, intp_file, setipnum} word.
- Buffers decoded words in a small FIFO and emits each as a one-cycle msi_info_vld pulse, paced to the gap the per-hart CSR gate needs to register every word.
- Sits between the interconnect MSI target and the per-hart IMSIC CSR gates.

Parameters:
- NR_INTP_FILES, 7, interrupt files per hart (M, S, VS...).
- NR_HARTS, 4, harts served.
- NR_HARTS_WIDTH, 2, hart id width.
- NR_SRC, 32, interrupt identities per file; legal setipnum is 1..NR_SRC-1.
- NR_SRC_WIDTH, $clog2(NR_SRC), setipnum field width.
- INTP_FILE_WIDTH, $clog2(NR_INTP_FILES), file index width.
- MSI_INFO_WIDTH, NR_HARTS_WIDTH+INTP_FILE_WIDTH+NR_SRC_WIDTH, packed word width (10 at defaults).
- ADDR_WIDTH, 32, bus address width.
- BASE_ADDR, 32'h2400_0000, window base; must be 4 KiB aligned.
- FIFO_DEPTH, 4, buffered entries; power of 2, ≥2.
- GAP_CYCLES, 1, minimum idle cycles between vld pulses (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_wr_vld  in  1  MSI write request valid.
- o_wr_rdy  out  1  write request accepted when i_wr_vld & o_wr_rdy.
- i_wr_addr  in  ADDR_WIDTH  write byte address.
- i_wr_data  in  32  write data; the identity is in the low bits.
- o_msi_info  out  MSI_INFO_WIDTH  {hart[MSB], file, setipnum[LSB]}.
- o_msi_info_vld  out  1  one-cycle pulse; word valid on o_msi_info.
- o_busy  out  1  FIFO non-empty or FSM not IDLE.
- o_drop_cnt  out  8  dropped-write count (optional feature).

Behaviour:
- Reset values: o_wr_rdy=0 while rst is high, then equal to !full; o_msi_info=0; o_msi_info_vld=0; o_busy=0; o_drop_cnt=0. FIFO is emptied and FSM goes to IDLE.
- Reset mid-operation: all buffered and in-flight words are discarded. No pulse is emitted after reset until a new write is accepted.
- Handshake: o_wr_rdy = !fifo_full, registered-state based with no pass-through. When full, a write is refused even if a pop occurs in the same cycle.
- Decode (only on accept):
  - off = i_wr_addr - BASE_ADDR.
  - file = off[12 +: INTP_FILE_WIDTH].
  - hart = off[12+INTP_FILE_WIDTH +: NR_HARTS_WIDTH].
  - id = i_wr_data[NR_SRC_WIDTH-1:0].
- Legal write, all of the following hold:
  - i_wr_addr >= BASE_ADDR;
  - off >> (12+INTP_FILE_WIDTH+NR_HARTS_WIDTH) == 0;
  - off[11:0] == 0 (seteipnum_le only);
  - file < NR_INTP_FILES;
  - hart < NR_HARTS;
  - i_wr_data != 0 and i_wr_data < NR_SRC, compared on all 32 bits.
- Illegal writes are still accepted (o_wr_rdy semantics unchanged), are not pushed, and produce no pulse.
- Push: a legal accept in cycle N writes the FIFO at the clk edge ending N.
- Output FSM:
  - IDLE: FIFO non-empty -> SEND.
  - SEND: pop head; drive o_msi_info=head, o_msi_info_vld=1 for exactly this cycle. Then -> GAP if GAP_CYCLES>0, else IDLE.
  - GAP: count GAP_CYCLES cycles, then -> IDLE.
- Latency: legal accept in cycle N gives a pulse in cycle N+2 when the FSM is IDLE and the FIFO is empty.
- Sustained rate: one pulse per (2+GAP_CYCLES) cycles, because IDLE costs one cycle.
- o_msi_info holds the last sent word between pulses. Order is strictly FIFO.
- Simultaneous push and pop when not full: both occur; the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH; full/empty use an extra wrap bit.

Optional Feature:
- Macro IMSIC_MSI_SENDER_DROP_CNT_EN.
- Defined: o_drop_cnt increments by 1 on each accepted illegal write and saturates at 8'hFF. It clears only on rst.
- Undefined: o_drop_cnt is tied to 0 and no counter logic is present. Datapath behaviour is otherwise identical.

Test Plan:
- Write addr 0x2400_1000, data 5, accepted cycle N -> o_msi_info=10'h025, o_msi_info_vld high only in cycle N+2.
- Write addr 0x2401_3000 (hart 2, file 3), data 31 -> o_msi_info=10'h27F, single pulse.
- Illegal writes, each accepted with no pulse; with the macro, o_drop_cnt=4 afterwards:
  - data 0 to 0x2400_0000;
  - data 32 to 0x2400_0000;
  - data 3 to 0x2400_7000 (file 7);
  - data 3 to 0x2400_0004 (offset != 0).
- 6 back-to-back legal writes, ids 1..6, GAP_CYCLES=1 -> o_wr_rdy drops while 4 entries are held; all 6 pulses arrive in order, spaced exactly 3 cycles apart.
- Assert rst with 3 entries buffered, mid-GAP -> outputs 0 immediately; no pulses after release until a new write; the next write gives a pulse at N+2.
- With the macro, 260 illegal writes -> o_drop_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/imsic_msi_sender.sv
// imsic_msi_sender: decodes posted MSI writes into {hart, file, setipnum} words, buffers
// them and emits paced one-cycle pulses. Optional macro: IMSIC_MSI_SENDER_DROP_CNT_EN.
module imsic_msi_sender #(
   parameter int NR_INTP_FILES   = 7,
   parameter int NR_HARTS        = 4,
   parameter int NR_HARTS_WIDTH  = 2,
   parameter int NR_SRC          = 32,
   parameter int NR_SRC_WIDTH    = $clog2(NR_SRC),
   parameter int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
   parameter int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
   parameter int ADDR_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h2400_0000,
   parameter int FIFO_DEPTH      = 4,
   parameter int GAP_CYCLES      = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_wr_vld,
   output logic                      o_wr_rdy,
   input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
   input  logic [31:0]               i_wr_data,
   output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
   output logic                      o_msi_info_vld,
   output logic                      o_busy,
   output logic [7:0]                o_drop_cnt
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int WIN_LSB = 12 + INTP_FILE_WIDTH + NR_HARTS_WIDTH;
   localparam logic [PTR_W:0] PTR_ONE  = 1;
   localparam logic [3:0]     GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
   } state_t;

   // Elaboration-time parameter sanity.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_chk_gap
      $error("GAP_CYCLES must be in 0..15");
   end
   if (BASE_ADDR[11:0] != 12'h000) begin : g_chk_base
      $error("BASE_ADDR must be 4 KiB aligned");
   end

   logic [ADDR_WIDTH-1:0]      off;
   logic [INTP_FILE_WIDTH-1:0] dec_file;
   logic [NR_HARTS_WIDTH-1:0]  dec_hart;
   logic [NR_SRC_WIDTH-1:0]    dec_id;
   logic                       wr_legal;
   logic                       wr_acc;
   logic                       push;
   logic                       pop;
   logic                       full;
   logic                       empty;

   logic [MSI_INFO_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W:0]             wr_ptr;
   logic [PTR_W:0]             rd_ptr;

   state_t                     state;
   logic [3:0]                 gap_cnt;

   // Window decode: one 4 KiB page per (hart, file), seteipnum_le at page offset 0.
   assign off      = i_wr_addr - BASE_ADDR;
   assign dec_file = off[12 +: INTP_FILE_WIDTH];
   assign dec_hart = off[12 + INTP_FILE_WIDTH +: NR_HARTS_WIDTH];
   assign dec_id   = i_wr_data[NR_SRC_WIDTH-1:0];

   assign wr_legal = (i_wr_addr >= BASE_ADDR)
                  && ((off >> WIN_LSB) == '0)
                  && (off[11:0] == 12'h000)
                  && (32'(dec_file) < 32'(NR_INTP_FILES))
                  && (32'(dec_hart) < 32'(NR_HARTS))
                  && (i_wr_data != 32'h0)
                  && (i_wr_data < 32'(NR_SRC));

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W])
               && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign o_wr_rdy = ~rst & ~full;
   assign wr_acc   = i_wr_vld & o_wr_rdy;
   assign push     = wr_acc & wr_legal;
   assign pop      = (state == S_SEND);
   assign o_busy   = ~empty | (state != S_IDLE);

   // NOTE: the storage array is deliberately not reset; the pointers alone say which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[PTR_W-1:0]] <= {dec_hart, dec_file, dec_id};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         gap_cnt        <= 4'd0;
         o_msi_info     <= '0;
         o_msi_info_vld <= 1'b0;
      end else begin
         // NOTE: default-low first, then set in one branch, makes the pulse exactly one cycle wide.
         o_msi_info_vld <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!empty) begin
                  state          <= S_SEND;
                  o_msi_info     <= mem[rd_ptr[PTR_W-1:0]];
                  o_msi_info_vld <= 1'b1;
               end
            end
            S_SEND: begin
               if (GAP_CYCLES > 0) begin
                  state   <= S_GAP;
                  gap_cnt <= GAP_LOAD;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_GAP: begin
               if (gap_cnt == 4'd0) state <= S_IDLE;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef IMSIC_MSI_SENDER_DROP_CNT_EN
   logic [7:0] drop_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= 8'h00;
      end else if (wr_acc && !wr_legal && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign o_drop_cnt = drop_cnt;
`else
   assign o_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_imsic_msi_sender.sv
// Bench for imsic_msi_sender: directed and randomized writes checked against a
// timing-level reference model (pulse time = max(push+2, previous pulse+2+GAP)).
module tb_imsic_msi_sender;

   localparam int NR_INTP_FILES  = 7;
   localparam int NR_HARTS       = 4;
   localparam int NR_HARTS_WIDTH = 2;
   localparam int NR_SRC         = 32;
   localparam int MSI_W          = 10;
   localparam int ADDR_WIDTH     = 32;
   localparam logic [31:0] BASE_ADDR = 32'h2400_0000;
   localparam int FIFO_DEPTH     = 4;
   localparam int GAP_CYCLES     = 1;
`ifdef IMSIC_MSI_SENDER_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_vld = 1'b0;
   logic             wr_rdy;
   logic [31:0]      wr_addr = '0;
   logic [31:0]      wr_data = '0;
   logic [MSI_W-1:0] msi_info;
   logic             msi_info_vld;
   logic             busy;
   logic [7:0]       drop_cnt;

   always #5 clk = ~clk;

   imsic_msi_sender #(
      .NR_INTP_FILES (NR_INTP_FILES),
      .NR_HARTS      (NR_HARTS),
      .NR_HARTS_WIDTH(NR_HARTS_WIDTH),
      .NR_SRC        (NR_SRC),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .BASE_ADDR     (BASE_ADDR),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .GAP_CYCLES    (GAP_CYCLES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_wr_vld      (wr_vld),
      .o_wr_rdy      (wr_rdy),
      .i_wr_addr     (wr_addr),
      .i_wr_data     (wr_data),
      .o_msi_info    (msi_info),
      .o_msi_info_vld(msi_info_vld),
      .o_busy        (busy),
      .o_drop_cnt    (drop_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: scheduled pulse cycle and word per buffered entry.
   int               pq[$];
   logic [MSI_W-1:0] wq[$];
   logic [MSI_W-1:0] last_word = '0;
   int               last_p     = -1000;
   int               last_sched = -1000;
   int               drop_exp   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic ref_decode(input logic [31:0] addr, input logic [31:0] data,
                                       output logic [MSI_W-1:0] word);
      longint off, page;
      int file, hart;
      word = '0;
      if (addr < BASE_ADDR) return 1'b0;
      off = longint'(addr) - longint'(BASE_ADDR);
      if (off % 4096 != 0) return 1'b0;
      page = off / 4096;
      file = int'(page % 8);
      hart = int'(page / 8);
      if (file >= NR_INTP_FILES || hart >= NR_HARTS) return 1'b0;
      if (data == 0 || data >= NR_SRC) return 1'b0;
      word = MSI_W'(hart * 256 + file * 32 + int'(data));
      return 1'b1;
   endfunction

   function automatic void model_reset();
      pq.delete();
      wq.delete();
      last_word  = '0;
      last_p     = -1000;
      last_sched = -1000;
      drop_exp   = 0;
   endfunction

   // Called in the middle of a cycle: check outputs, drive inputs, advance one cycle.
   task automatic step(input logic vld, input logic [31:0] addr, input logic [31:0] data,
                       output logic accepted);
      logic             exp_vld, exp_rdy, exp_busy;
      logic [MSI_W-1:0] exp_info, word;
      int               occ, sched;
      occ      = pq.size();
      exp_vld  = (occ > 0) && (pq[0] == cyc);
      exp_info = exp_vld ? wq[0] : last_word;
      exp_rdy  = (occ < FIFO_DEPTH);
      exp_busy = (occ > 0) || (cyc - last_p <= GAP_CYCLES);
      check("vld",  32'(msi_info_vld), 32'(exp_vld));
      check("info", 32'(msi_info),     32'(exp_info));
      check("rdy",  32'(wr_rdy),       32'(exp_rdy));
      check("busy", 32'(busy),         32'(exp_busy));
      check("drop", 32'(drop_cnt),     32'(drop_exp));
      if (exp_vld) begin
         last_word = wq.pop_front();
         void'(pq.pop_front());
         last_p = cyc;
      end
      wr_vld   = vld;
      wr_addr  = addr;
      wr_data  = data;
      accepted = vld && exp_rdy;
      if (accepted) begin
         if (ref_decode(addr, data, word)) begin
            sched = (cyc + 2 > last_sched + 2 + GAP_CYCLES) ? cyc + 2 : last_sched + 2 + GAP_CYCLES;
            pq.push_back(sched);
            wq.push_back(word);
            last_sched = sched;
         end else if (DROP_EN && drop_exp < 255) begin
            drop_exp++;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      wr_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, acc);
   endtask

   task automatic drain();
      int budget = 60;
      while (pq.size() > 0 && budget > 0) begin
         idle(1);
         budget--;
      end
      check("drain_timeout", 32'(pq.size()), 32'd0);
      idle(3);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_vld",  32'(msi_info_vld), 32'd0);
      check("rst_info", 32'(msi_info),     32'd0);
      check("rst_busy", 32'(busy),         32'd0);
      check("rst_rdy",  32'(wr_rdy),       32'd0);
      check("rst_drop", 32'(drop_cnt),     32'd0);
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
   endtask

   function automatic void rand_wr(output logic [31:0] a, output logic [31:0] d);
      int r;
      r = int'($urandom_range(0, 11));
      a = BASE_ADDR + 32'($urandom_range(0, 31)) * 32'h1000;
      d = 32'($urandom_range(1, 31));
      case (r)
         0: a = a + 32'($urandom_range(1, 4095));
         1: d = 32'h0;
         2: d = 32'($urandom_range(32, 5000));
         3: a = $urandom();
         4: a = BASE_ADDR - 32'($urandom_range(1, 8)) * 32'h1000;
         default: ;
      endcase
   endfunction

   initial begin
      logic        acc, saw_low;
      logic [31:0] a, d;
      int          k, budget;

      // Reset state while rst is held from time zero.
      #3;
      check("init_vld",  32'(msi_info_vld), 32'd0);
      check("init_info", 32'(msi_info),     32'd0);
      check("init_busy", 32'(busy),         32'd0);
      check("init_rdy",  32'(wr_rdy),       32'd0);
      check("init_drop", 32'(drop_cnt),     32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      idle(3);

      // Basic write: pulse two cycles after accept.
      step(1'b1, 32'h2400_1000, 32'd5, acc);
      check("t1_acc", 32'(acc), 32'd1);
      idle(1);
      check("t1_vld",  32'(msi_info_vld), 32'd1);
      check("t1_info", 32'(msi_info),     32'h025);
      drain();

      step(1'b1, 32'h2401_3000, 32'd31, acc);
      idle(1);
      check("t2_vld",  32'(msi_info_vld), 32'd1);
      check("t2_info", 32'(msi_info),     32'h27F);
      drain();

      // Illegal writes: accepted, no pulse.
      step(1'b1, 32'h2400_0000, 32'd0,  acc);
      step(1'b1, 32'h2400_0000, 32'd32, acc);
      step(1'b1, 32'h2400_7000, 32'd3,  acc);
      step(1'b1, 32'h2400_0004, 32'd3,  acc);
      idle(4);
      check("drop4", 32'(drop_cnt), DROP_EN ? 32'd4 : 32'd0);

      // Back-to-back legal writes, ids 1..6.
      k = 0; budget = 100; saw_low = 1'b0;
      while (k < 6 && budget > 0) begin
         if (!wr_rdy) saw_low = 1'b1;
         step(1'b1, 32'h2400_0000, 32'(k + 1), acc);
         if (acc) k++;
         budget--;
      end
      check("b2b_count", 32'(k), 32'd6);
      drain();
      check("b2b_rdy_low_seen", 32'(saw_low), 32'd1);

      // Drop counter saturation.
      for (int i = 0; i < 260; i++) step(1'b1, BASE_ADDR, 32'd0, acc);
      check("drop_sat", 32'(drop_cnt), DROP_EN ? 32'hFF : 32'd0);

      // Reset mid-GAP with three entries buffered.
      budget = 40; k = 0;
      while (!(last_p == cyc - 1 && pq.size() == 3) && budget > 0) begin
         step(1'b1, BASE_ADDR + 32'((k % 28) * 32'h1000), 32'((k % 31) + 1), acc);
         k++;
         budget--;
      end
      check("pre_rst_busy", 32'(busy), 32'd1);
      do_reset();
      idle(10);
      step(1'b1, 32'h2400_2000, 32'd7, acc);
      idle(1);
      check("post_rst_vld",  32'(msi_info_vld), 32'd1);
      check("post_rst_info", 32'(msi_info),     32'h047);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         rand_wr(a, d);
         step($urandom_range(0, 3) != 0, a, d, acc);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
